rc4_key_search_ctrl: RTL and testbench

Top-level scheduler for the RC4 brute-force key search. For each candidate secret key, it runs three phases in order on the shared 256x8 working memory S: init (S[i]=i), shuffle (key scheduling) and decrypt. It owns the single S-memory port and grants it to exactly one phase engine at a time. It advances the key until decrypt reports a valid plaintext or the key range is exhausted.

---
 rtl/rc4_pkg.sv | 37 +++
 rtl/rc4_key_search_ctrl_if.sv | 60 ++++++
 rtl/s_mem_port_mux.sv | 49 ++++
 rtl/rc4_key_search_ctrl.sv | 110 +++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key search controller slice.
package rc4_pkg;

  localparam int KEY_WIDTH    = 24;
  localparam int S_ADDR_WIDTH = 8;
  localparam int S_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    SHUF_GO,
    SHUF_WAIT,
    DEC_GO,
    DEC_WAIT,
    NEXT_KEY,
    DONE
  } rc4_ctrl_state_t;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_INIT,
    PH_SHUF,
    PH_DEC
  } rc4_phase_t;

  // Which engine owns the S port in a given controller state.
  function automatic rc4_phase_t phase_of(input rc4_ctrl_state_t st);
    case (st)
      INIT_GO, INIT_WAIT: phase_of = PH_INIT;
      SHUF_GO, SHUF_WAIT: phase_of = PH_SHUF;
      DEC_GO, DEC_WAIT:   phase_of = PH_DEC;
      default:            phase_of = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Handshake and S-memory bus between the key search controller and its phase engines.
interface rc4_key_search_ctrl_if
  import rc4_pkg::*;
#(
  parameter int KEY_WIDTH  = rc4_pkg::KEY_WIDTH,
  parameter int ADDR_WIDTH = rc4_pkg::S_ADDR_WIDTH,
  parameter int DATA_WIDTH = rc4_pkg::S_DATA_WIDTH
) ();

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [KEY_WIDTH-1:0]  key;

  logic                  init_start;
  logic                  shuffle_start;
  logic                  decrypt_start;
  logic                  init_fin;
  logic                  shuffle_fin;
  logic                  decrypt_fin;
  logic                  decrypt_valid;

  logic [ADDR_WIDTH-1:0] init_addr;
  logic [ADDR_WIDTH-1:0] shuffle_addr;
  logic [ADDR_WIDTH-1:0] decrypt_addr;
  logic [DATA_WIDTH-1:0] init_wdata;
  logic [DATA_WIDTH-1:0] shuffle_wdata;
  logic [DATA_WIDTH-1:0] decrypt_wdata;
  logic                  init_wren;
  logic                  shuffle_wren;
  logic                  decrypt_wren;

  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_wren;

  // Controller side.
  modport master (
    input  start, init_fin, shuffle_fin, decrypt_fin, decrypt_valid,
           init_addr, shuffle_addr, decrypt_addr,
           init_wdata, shuffle_wdata, decrypt_wdata,
           init_wren, shuffle_wren, decrypt_wren,
    output busy, done, found, key,
           init_start, shuffle_start, decrypt_start,
           s_addr, s_wdata, s_wren
  );

  // Engine / host side.
  modport slave (
    output start, init_fin, shuffle_fin, decrypt_fin, decrypt_valid,
           init_addr, shuffle_addr, decrypt_addr,
           init_wdata, shuffle_wdata, decrypt_wdata,
           init_wren, shuffle_wren, decrypt_wren,
    input  busy, done, found, key,
           init_start, shuffle_start, decrypt_start,
           s_addr, s_wdata, s_wren
  );

endinterface

// File: rtl/s_mem_port_mux.sv
// 3:1 S-memory port mux; the selected phase engine drives the single S port,
// and with no owner the port is parked at zero so nothing is written.
module s_mem_port_mux
  import rc4_pkg::*;
#(
  parameter int ADDR_WIDTH = rc4_pkg::S_ADDR_WIDTH,
  parameter int DATA_WIDTH = rc4_pkg::S_DATA_WIDTH
) (
  input  rc4_phase_t            phase_i,
  input  logic [ADDR_WIDTH-1:0] init_addr_i,
  input  logic [DATA_WIDTH-1:0] init_wdata_i,
  input  logic                  init_wren_i,
  input  logic [ADDR_WIDTH-1:0] shuffle_addr_i,
  input  logic [DATA_WIDTH-1:0] shuffle_wdata_i,
  input  logic                  shuffle_wren_i,
  input  logic [ADDR_WIDTH-1:0] decrypt_addr_i,
  input  logic [DATA_WIDTH-1:0] decrypt_wdata_i,
  input  logic                  decrypt_wren_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  output logic                  s_wren_o
);

  // Route the owning engine's request to the S port.
  always_comb begin
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wren_o  = 1'b0;
    case (phase_i)
      PH_INIT: begin
        s_addr_o  = init_addr_i;
        s_wdata_o = init_wdata_i;
        s_wren_o  = init_wren_i;
      end
      PH_SHUF: begin
        s_addr_o  = shuffle_addr_i;
        s_wdata_o = shuffle_wdata_i;
        s_wren_o  = shuffle_wren_i;
      end
      PH_DEC: begin
        s_addr_o  = decrypt_addr_i;
        s_wdata_o = decrypt_wdata_i;
        s_wren_o  = decrypt_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force key search scheduler: walks candidate keys from KEY_START to
// KEY_END, running init, shuffle and decrypt on the shared S memory per key,
// and stops on the first key that decrypt reports as valid.
module rc4_key_search_ctrl #(
  parameter int                   KEY_WIDTH  = rc4_pkg::KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_START  = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_END    = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   ADDR_WIDTH = rc4_pkg::S_ADDR_WIDTH,
  parameter int                   DATA_WIDTH = rc4_pkg::S_DATA_WIDTH
) (
  input logic                  clk,
  input logic                  reset,
  rc4_key_search_ctrl_if.master bus
);

  import rc4_pkg::*;

  rc4_ctrl_state_t      state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 found_q, found_d;

  // State, key and result registers; synchronous reset aborts any search.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= KEY_START;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      found_q <= found_d;
    end
  end

  // Phase sequencing and key advance; fin pulses only count in their own WAIT state.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    found_d = found_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = INIT_GO;
          key_d   = KEY_START;
          found_d = 1'b0;
        end
      end
      INIT_GO:   state_d = INIT_WAIT;
      INIT_WAIT: if (bus.init_fin) state_d = SHUF_GO;
      SHUF_GO:   state_d = SHUF_WAIT;
      SHUF_WAIT: if (bus.shuffle_fin) state_d = DEC_GO;
      DEC_GO:    state_d = DEC_WAIT;
      DEC_WAIT: begin
        if (bus.decrypt_fin) begin
          if (bus.decrypt_valid) begin
            state_d = DONE;
            found_d = 1'b1;
          end else if (key_q == KEY_END) begin
            state_d = DONE;
            found_d = 1'b0;
          end else begin
            state_d = NEXT_KEY;
          end
        end
      end
      NEXT_KEY: begin
        key_d   = key_q + KEY_WIDTH'(1);
        state_d = INIT_GO;
      end
      DONE: begin
        if (bus.start) begin
          state_d = INIT_GO;
          key_d   = KEY_START;
          found_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Launch pulses and status are pure decodes of the registered state, so the
  // GO states (one cycle each) give single-cycle start pulses.
  assign bus.init_start    = (state_q == INIT_GO);
  assign bus.shuffle_start = (state_q == SHUF_GO);
  assign bus.decrypt_start = (state_q == DEC_GO);
  assign bus.busy          = (state_q != IDLE) && (state_q != DONE);
  assign bus.done          = (state_q == DONE);
  assign bus.found         = found_q;
  assign bus.key           = key_q;

  s_mem_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .phase_i         (phase_of(state_q)),
    .init_addr_i     (bus.init_addr),
    .init_wdata_i    (bus.init_wdata),
    .init_wren_i     (bus.init_wren),
    .shuffle_addr_i  (bus.shuffle_addr),
    .shuffle_wdata_i (bus.shuffle_wdata),
    .shuffle_wren_i  (bus.shuffle_wren),
    .decrypt_addr_i  (bus.decrypt_addr),
    .decrypt_wdata_i (bus.decrypt_wdata),
    .decrypt_wren_i  (bus.decrypt_wren),
    .s_addr_o        (bus.s_addr),
    .s_wdata_o       (bus.s_wdata),
    .s_wren_o        (bus.s_wren)
  );

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with KEY_START=0, KEY_END=3 and
// engine models that finish 5 cycles after their start pulse.
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_key_search_ctrl_if #(.KEY_WIDTH(24), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  rc4_key_search_ctrl #(
    .KEY_WIDTH  (24),
    .KEY_START  (24'h000000),
    .KEY_END    (24'h000003),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int n_init = 0, n_shuf = 0, n_dec = 0, n_double = 0;
  logic [2:0] prev_starts = 3'b000;

  // Count launch pulses and flag any start held for two cycles.
  always @(negedge clk) begin
    if (bus.init_start)    n_init <= n_init + 1;
    if (bus.shuffle_start) n_shuf <= n_shuf + 1;
    if (bus.decrypt_start) n_dec  <= n_dec + 1;
    if ((prev_starts & {bus.init_start, bus.shuffle_start, bus.decrypt_start}) != 3'b000)
      n_double <= n_double + 1;
    prev_starts <= {bus.init_start, bus.shuffle_start, bus.decrypt_start};
  end

  function automatic logic start_of(input int ph);
    case (ph)
      0:       return bus.init_start;
      1:       return bus.shuffle_start;
      default: return bus.decrypt_start;
    endcase
  endfunction

  task automatic drive_fin(input int ph, input logic lvl);
    case (ph)
      0:       bus.init_fin = lvl;
      1:       bus.shuffle_fin = lvl;
      default: bus.decrypt_fin = lvl;
    endcase
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Engine model: wait (bounded) for the phase start, finish 5 cycles later.
  task automatic run_phase(input int ph, input logic valid, output logic ok, output int lat,
                           output logic [16:0] grant_go, output logic [16:0] grant_wait,
                           output logic [23:0] key_go);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (start_of(ph)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    grant_go   = {bus.s_addr, bus.s_wdata, bus.s_wren};
    key_go     = bus.key;
    grant_wait = '0;
    if (!ok) return;
    @(negedge clk);
    grant_wait = {bus.s_addr, bus.s_wdata, bus.s_wren};
    repeat (3) @(negedge clk);
    drive_fin(ph, 1'b1);
    if (ph == 2) bus.decrypt_valid = valid;
    @(negedge clk);
    drive_fin(ph, 1'b0);
    bus.decrypt_valid = 1'b0;
  endtask

  task automatic run_key(input logic valid, output logic ok, output int lat_i, output int lat_s,
                         output int lat_d, output logic [23:0] key_i);
    logic ok0, ok1, ok2;
    logic [16:0] g0, g1;
    logic [23:0] k;
    run_phase(0, 1'b0, ok0, lat_i, g0, g1, key_i);
    run_phase(1, 1'b0, ok1, lat_s, g0, g1, k);
    run_phase(2, valid, ok2, lat_d, g0, g1, k);
    ok = ok0 && ok1 && ok2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.found, bus.init_start, bus.shuffle_start, bus.decrypt_start} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.busy, bus.done, bus.found, bus.init_start, bus.shuffle_start, bus.decrypt_start});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.key !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_key: got %h want 000000", bus.key);
    end
    n_checks++;
    if ({bus.s_addr, bus.s_wdata, bus.s_wren} !== 17'h0) begin
      n_fail++;
      $display("FAIL idle_grant: got %h want 00000", {bus.s_addr, bus.s_wdata, bus.s_wren});
    end
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_hold: got busy/done %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_single_key();
    logic ok;
    int li, ls, ld, i0, s0, d0;
    logic [23:0] k;
    i0 = n_init; s0 = n_shuf; d0 = n_dec;
    pulse_start();
    n_checks++;
    if ({bus.init_start, bus.busy, bus.key} !== {2'b11, 24'h0}) begin
      n_fail++;
      $display("FAIL single_launch: got init_start=%b busy=%b key=%h want 1 1 000000",
               bus.init_start, bus.busy, bus.key);
    end
    run_key(1'b1, ok, li, ls, ld, k);
    n_checks++;
    if ({ok, li[3:0], ls[3:0], ld[3:0]} !== 13'b1_0000_0000_0000) begin
      n_fail++;
      $display("FAIL single_latency: got ok=%b lat=%0d/%0d/%0d want 1 0/0/0", ok, li, ls, ld);
    end
    n_checks++;
    if ({bus.done, bus.found, bus.busy, bus.key} !== {3'b110, 24'h0}) begin
      n_fail++;
      $display("FAIL single_result: got done=%b found=%b busy=%b key=%h want 1 1 0 000000",
               bus.done, bus.found, bus.busy, bus.key);
    end
    @(negedge clk);
    n_checks++;
    if ({n_init - i0, n_shuf - s0, n_dec - d0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL single_pulses: got %0d/%0d/%0d want 1/1/1", n_init - i0, n_shuf - s0, n_dec - d0);
    end
  endtask

  task automatic test_search();
    logic ok;
    int li, ls, ld, i0;
    logic [23:0] k;
    i0 = n_init;
    pulse_start();
    n_checks++;
    if ({bus.found, bus.done, bus.busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL search_restart: got found/done/busy %b want 001", {bus.found, bus.done, bus.busy});
    end
    for (int kk = 0; kk < 4; kk++) begin
      run_key(kk == 3, ok, li, ls, ld, k);
      n_checks++;
      if (!ok || k !== 24'(kk) || li !== ((kk == 0) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL search_key%0d: got ok=%b key=%h init_lat=%0d want 1 %h %0d",
                 kk, ok, k, li, 24'(kk), (kk == 0) ? 0 : 1);
      end
      if (kk < 3) begin
        n_checks++;
        if ({bus.busy, bus.s_wren, bus.init_start, bus.done} !== 4'b1000 || bus.key !== 24'(kk)) begin
          n_fail++;
          $display("FAIL next_key%0d: got busy=%b wren=%b init_start=%b done=%b key=%h want 1 0 0 0 %h",
                   kk, bus.busy, bus.s_wren, bus.init_start, bus.done, bus.key, 24'(kk));
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.found, bus.key} !== {2'b11, 24'h3} || (n_init - i0) !== 4) begin
      n_fail++;
      $display("FAIL search_result: got done=%b found=%b key=%h inits=%0d want 1 1 000003 4",
               bus.done, bus.found, bus.key, n_init - i0);
    end
  endtask

  task automatic test_exhaustion();
    logic ok, all_ok;
    int li, ls, ld;
    logic [23:0] k;
    all_ok = 1'b1;
    pulse_start();
    for (int kk = 0; kk < 4; kk++) begin
      run_key(1'b0, ok, li, ls, ld, k);
      all_ok = all_ok && ok;
    end
    n_checks++;
    if ({all_ok, bus.done, bus.found, bus.key} !== {3'b110, 24'h3}) begin
      n_fail++;
      $display("FAIL exhaust_result: got ok=%b done=%b found=%b key=%h want 1 1 0 000003",
               all_ok, bus.done, bus.found, bus.key);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.done, bus.busy, bus.init_start, bus.s_wren, bus.key} !== {4'b1000, 24'h3}) begin
      n_fail++;
      $display("FAIL exhaust_hold: got done=%b busy=%b init_start=%b wren=%b key=%h want 1 0 0 0 000003",
               bus.done, bus.busy, bus.init_start, bus.s_wren, bus.key);
    end
  endtask

  task automatic test_grant();
    logic ok;
    int lat;
    logic [16:0] gg, gw;
    logic [23:0] k;
    pulse_start();
    run_phase(0, 1'b0, ok, lat, gg, gw, k);
    n_checks++;
    if (!ok || gg !== {8'h11, 8'hA1, 1'b1} || gw !== {8'h11, 8'hA1, 1'b1}) begin
      n_fail++;
      $display("FAIL grant_init: got ok=%b go=%h wait=%h want 1 %h", ok, gg, gw, {8'h11, 8'hA1, 1'b1});
    end
    run_phase(1, 1'b0, ok, lat, gg, gw, k);
    n_checks++;
    if (!ok || gg !== {8'h22, 8'hB2, 1'b1} || gw !== {8'h22, 8'hB2, 1'b1}) begin
      n_fail++;
      $display("FAIL grant_shuf: got ok=%b go=%h wait=%h want 1 %h", ok, gg, gw, {8'h22, 8'hB2, 1'b1});
    end
    run_phase(2, 1'b1, ok, lat, gg, gw, k);
    n_checks++;
    if (!ok || gg !== {8'h33, 8'hC3, 1'b1} || gw !== {8'h33, 8'hC3, 1'b1}) begin
      n_fail++;
      $display("FAIL grant_dec: got ok=%b go=%h wait=%h want 1 %h", ok, gg, gw, {8'h33, 8'hC3, 1'b1});
    end
    n_checks++;
    if ({bus.done, bus.s_addr, bus.s_wdata, bus.s_wren} !== 18'h20000) begin
      n_fail++;
      $display("FAIL grant_done: got done=%b grant=%h want 1 00000", bus.done,
               {bus.s_addr, bus.s_wdata, bus.s_wren});
    end
  endtask

  task automatic test_spurious();
    logic ok;
    int lat, i0, s0, d0;
    logic [16:0] gg, gw;
    logic [23:0] k;
    i0 = n_init; s0 = n_shuf; d0 = n_dec;
    pulse_start();
    @(negedge clk);
    bus.shuffle_fin   = 1'b1;
    bus.decrypt_fin   = 1'b1;
    bus.decrypt_valid = 1'b1;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.shuffle_fin   = 1'b0;
    bus.decrypt_fin   = 1'b0;
    bus.decrypt_valid = 1'b0;
    bus.start         = 1'b0;
    n_checks++;
    if ({bus.init_start, bus.shuffle_start, bus.decrypt_start, bus.busy, bus.done} !== 5'b00010 ||
        bus.s_addr !== 8'h11) begin
      n_fail++;
      $display("FAIL spurious_hold: got starts=%b busy=%b done=%b addr=%h want 000 1 0 11",
               {bus.init_start, bus.shuffle_start, bus.decrypt_start}, bus.busy, bus.done, bus.s_addr);
    end
    bus.init_fin = 1'b1;
    @(negedge clk);
    bus.init_fin = 1'b0;
    n_checks++;
    if ({bus.shuffle_start, bus.s_addr} !== {1'b1, 8'h22}) begin
      n_fail++;
      $display("FAIL spurious_recover: got shuffle_start=%b addr=%h want 1 22", bus.shuffle_start, bus.s_addr);
    end
    run_phase(1, 1'b0, ok, lat, gg, gw, k);
    run_phase(2, 1'b1, ok, lat, gg, gw, k);
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.found, bus.key} !== {2'b11, 24'h0} ||
        {n_init - i0, n_shuf - s0, n_dec - d0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL spurious_result: got done=%b found=%b key=%h pulses=%0d/%0d/%0d want 1 1 000000 1/1/1",
               bus.done, bus.found, bus.key, n_init - i0, n_shuf - s0, n_dec - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int li, ls, ld, lat;
    logic [16:0] gg, gw;
    logic [23:0] k;
    pulse_start();
    run_key(1'b0, ok, li, ls, ld, k);
    run_phase(0, 1'b0, ok, lat, gg, gw, k);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.shuffle_start, bus.s_addr, bus.key} !== {2'b10, 8'h22, 24'h1}) begin
      n_fail++;
      $display("FAIL mid_setup: got busy=%b shuffle_start=%b addr=%h key=%h want 1 0 22 000001",
               bus.busy, bus.shuffle_start, bus.s_addr, bus.key);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.found, bus.init_start, bus.shuffle_start, bus.decrypt_start,
         bus.s_addr, bus.s_wdata, bus.s_wren, bus.key} !== 47'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got flags=%b grant=%h key=%h want all zero",
               {bus.busy, bus.done, bus.found, bus.init_start, bus.shuffle_start, bus.decrypt_start},
               {bus.s_addr, bus.s_wdata, bus.s_wren}, bus.key);
    end
    pulse_start();
    n_checks++;
    if ({bus.init_start, bus.key} !== {1'b1, 24'h0}) begin
      n_fail++;
      $display("FAIL mid_restart: got init_start=%b key=%h want 1 000000", bus.init_start, bus.key);
    end
    run_key(1'b1, ok, li, ls, ld, k);
    n_checks++;
    if ({ok, bus.done, bus.found, bus.key} !== {3'b111, 24'h0}) begin
      n_fail++;
      $display("FAIL mid_result: got ok=%b done=%b found=%b key=%h want 1 1 1 000000",
               ok, bus.done, bus.found, bus.key);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.init_fin      = 1'b0;
    bus.shuffle_fin   = 1'b0;
    bus.decrypt_fin   = 1'b0;
    bus.decrypt_valid = 1'b0;
    bus.init_addr     = 8'h11;
    bus.init_wdata    = 8'hA1;
    bus.init_wren     = 1'b1;
    bus.shuffle_addr  = 8'h22;
    bus.shuffle_wdata = 8'hB2;
    bus.shuffle_wren  = 1'b1;
    bus.decrypt_addr  = 8'h33;
    bus.decrypt_wdata = 8'hC3;
    bus.decrypt_wren  = 1'b1;

    test_reset();
    test_single_key();
    test_search();
    test_exhaustion();
    test_grant();
    test_spurious();
    test_reset_mid();

    @(negedge clk);
    n_checks++;
    if (n_double !== 0) begin
      n_fail++;
      $display("FAIL start_width: got %0d double-cycle start pulses want 0", n_double);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
